target_lut_loader: RTL and testbench
====================================

// Module: target_lut_loader
// PURPOSE
//  Writer side of the branch-target lookup table: after start, reads DEPTH 16-bit targets from
//  byte-wide data memory (two reads each, hi byte first) into a register table, then serves
//  combinational index->target lookups to the fetch stage. Sits between data memory and PC logic.
// PARAMETERS
//  IDX_W      5       lookup index width; DEPTH = 2**IDX_W entries
//  TGT_W      16      target width (fixed 2 bytes; other values unsupported)
//  ADDR_W     8       data-memory byte address width
//  BASE_ADDR  8'd128  byte address of entry 0 hi byte
// PORTS
//  CLK         in   1       clock
//  reset       in   1       synchronous, active-high reset
//  start       in   1       pulse: begin (re)load; sampled only in IDLE or DONE
//  mem_rd_en   out  1       memory read strobe
//  mem_addr    out  ADDR_W  memory byte address
//  mem_rdata   in   8       memory data, valid the cycle after mem_rd_en
//  busy        out  1       load in progress
//  ready       out  1       table fully loaded; lookups valid
//  lut_idx     in   IDX_W   lookup index
//  lut_target  out  TGT_W   table[lut_idx] when ready, else 0
// BEHAVIOUR
//  - Reset: state IDLE, all entries 0, idx 0, hi latch 0; mem_rd_en=0, mem_addr=0, busy=0, ready=0.
//  - States: IDLE, RD_HI, RD_LO, WR_LAST, DONE.
//    IDLE/DONE --start--> RD_HI (idx=0, ready drops next cycle on reload).
//    RD_HI: rd_en=1, addr=BASE+2*idx; if idx!=0 write table[idx-1]={hi_latch,mem_rdata}; -> RD_LO.
//    RD_LO: rd_en=1, addr=BASE+2*idx+1; hi_latch<=mem_rdata; idx==DEPTH-1 ? ->WR_LAST : idx++,->RD_HI.
//    WR_LAST: rd_en=0; write table[DEPTH-1]={hi_latch,mem_rdata}; -> DONE.
//  - Latency: start sampled at cycle t0 -> ready=1 at t0+2*DEPTH+2 (66 cycles for DEPTH=32).
//  - busy=1 in RD_HI/RD_LO/WR_LAST; ready=1 only in DONE; mem_addr=0 whenever rd_en=0.
//  - Address arithmetic modulo 2**ADDR_W (wraps silently past 255).
//  - start while busy: ignored. start in DONE: full reload; table retains old values until overwritten,
//    but lut_target=0 throughout (ready=0).
//  - reset mid-load: returns to IDLE, clears table, abandons pending read (rdata next cycle ignored).
//  - Lookup path purely combinational; write and lookup of same entry same cycle returns old value.
// CONFIGURATION
//  TLL_RUNTIME_WR_EN defined: adds ports wr_en(in,1), wr_idx(in,IDX_W), wr_data(in,TGT_W);
//    in DONE only, wr_en writes table[wr_idx]<=wr_data at clock edge; ignored in other states;
//    loader writes always win (wr_en cannot occur outside DONE anyway).
//  Undefined: ports absent; table writable only by the loader.
// STRUCTURE
//  Package tll_pkg: state enum tll_state_t, IDX_W/TGT_W defaults, BYTES_PER_ENTRY=2.
//  Sub-module target_lut_ram: DEPTH x TGT_W regfile, 1 sync write port, 1 async read port,
//    sync clear on reset. FSM, idx counter, hi latch and address gen stay in target_lut_loader.
// TESTING
//  1 Reset then idle 10 cycles -> mem_rd_en=0, busy=0, ready=0, lut_target=0 for any lut_idx.
//  2 Memory model byte[128+2k]=k, byte[129+2k]=8'hA0+k; pulse start -> addr sequence 128,129,...,191;
//    ready at t0+66; lut_idx=5 -> 16'h05A5, lut_idx=31 -> 16'h1FBF.
//  3 start re-pulsed at t0+20 during load -> ignored; completion still at t0+66, no extra reads.
//  4 reset asserted at t0+30 -> next cycle IDLE, busy=0; after new start all entries reload correctly,
//    lut_idx=0 reads 0 before ready.
//  5 BASE_ADDR=8'd250, DEPTH=8 -> addr 250..255 then 0..9 (wrap); entry 3 built from bytes 0 and 1.
//  6 TLL_RUNTIME_WR_EN: in DONE wr_en idx=7 data=16'hBEEF -> lut_target(7)=16'hBEEF next cycle;
//    same write while busy -> no effect.

Source files
------------

// File: rtl/tll_pkg.sv
// Shared types and defaults for the branch-target LUT loader.
package tll_pkg;

  localparam int TLL_IDX_W       = 5;
  localparam int TLL_TGT_W       = 16;
  localparam int BYTES_PER_ENTRY = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_HI,
    ST_RD_LO,
    ST_WR_LAST,
    ST_DONE
  } tll_state_t;

endpackage

// File: rtl/target_lut_ram.sv
// DEPTH x TGT_W register file: one synchronous write port, one asynchronous read port, cleared by reset.
module target_lut_ram #(
  parameter int IDX_W = 5,
  parameter int TGT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  logic [TGT_W-1:0] wdata,
  input  logic [IDX_W-1:0] raddr,
  output logic [TGT_W-1:0] rdata
);

  localparam int DEPTH = 2**IDX_W;

  logic [TGT_W-1:0] table_q [DEPTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) table_q[i] <= '0;
    end else if (we) begin
      table_q[waddr] <= wdata;
    end
  end

  // Read sees the pre-edge contents, so a same-cycle write returns the old value.
  assign rdata = table_q[raddr];

endmodule

// File: rtl/target_lut_loader.sv
// Loads DEPTH 16-bit branch targets (hi byte first) from byte memory, then serves index lookups.
// Optional TLL_RUNTIME_WR_EN adds a runtime write port usable only once the table is loaded.
module target_lut_loader
  import tll_pkg::*;
#(
  parameter int                IDX_W     = TLL_IDX_W,
  parameter int                TGT_W     = TLL_TGT_W,
  parameter int                ADDR_W    = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(128)
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              start,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  output logic              busy,
  output logic              ready,
  input  logic [IDX_W-1:0]  lut_idx,
  output logic [TGT_W-1:0]  lut_target
`ifdef TLL_RUNTIME_WR_EN
  ,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [TGT_W-1:0]  wr_data
`endif
);

  localparam int               DEPTH    = 2**IDX_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  tll_state_t        state, state_nx;
  logic [IDX_W-1:0]  idx;
  logic [7:0]        hi_latch;
  logic [ADDR_W-1:0] entry_addr;

  logic              ld_we;
  logic [IDX_W-1:0]  ld_waddr;
  logic [TGT_W-1:0]  ld_wdata;
  logic              tbl_we;
  logic [IDX_W-1:0]  tbl_waddr;
  logic [TGT_W-1:0]  tbl_wdata;
  logic [TGT_W-1:0]  tbl_rdata;

  // Byte address of the hi byte of the current entry; wraps modulo 2**ADDR_W.
  assign entry_addr = BASE_ADDR + ADDR_W'(BYTES_PER_ENTRY) * ADDR_W'(idx);

  always_ff @(posedge CLK) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    mem_rd_en = 1'b0;
    mem_addr  = '0;
    busy      = 1'b0;
    ready     = 1'b0;
    ld_we     = 1'b0;
    ld_waddr  = idx;
    ld_wdata  = TGT_W'({hi_latch, mem_rdata});
    case (state)
      ST_IDLE: begin
        if (start) state_nx = ST_RD_HI;
      end
      ST_RD_HI: begin
        busy      = 1'b1;
        mem_rd_en = 1'b1;
        mem_addr  = entry_addr;
        // The lo byte arriving now completes the previous entry.
        if (idx != '0) begin
          ld_we    = 1'b1;
          ld_waddr = idx - IDX_W'(1);
        end
        state_nx = ST_RD_LO;
      end
      ST_RD_LO: begin
        busy      = 1'b1;
        mem_rd_en = 1'b1;
        mem_addr  = entry_addr + ADDR_W'(1);
        state_nx  = (idx == LAST_IDX) ? ST_WR_LAST : ST_RD_HI;
      end
      ST_WR_LAST: begin
        busy     = 1'b1;
        ld_we    = 1'b1;
        ld_waddr = LAST_IDX;
        state_nx = ST_DONE;
      end
      ST_DONE: begin
        ready = 1'b1;
        if (start) state_nx = ST_RD_HI;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      idx      <= '0;
      hi_latch <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) idx <= '0;
        end
        ST_RD_LO: begin
          hi_latch <= mem_rdata;
          if (idx != LAST_IDX) idx <= idx + IDX_W'(1);
        end
        default: ;
      endcase
    end
  end

`ifdef TLL_RUNTIME_WR_EN
  logic rt_we;
  assign rt_we     = wr_en && (state == ST_DONE);
  assign tbl_we    = ld_we | rt_we;
  assign tbl_waddr = ld_we ? ld_waddr : wr_idx;
  assign tbl_wdata = ld_we ? ld_wdata : wr_data;
`else
  assign tbl_we    = ld_we;
  assign tbl_waddr = ld_waddr;
  assign tbl_wdata = ld_wdata;
`endif

  target_lut_ram #(
    .IDX_W (IDX_W),
    .TGT_W (TGT_W)
  ) u_ram (
    .clk   (CLK),
    .reset (reset),
    .we    (tbl_we),
    .waddr (tbl_waddr),
    .wdata (tbl_wdata),
    .raddr (lut_idx),
    .rdata (tbl_rdata)
  );

  assign lut_target = ready ? tbl_rdata : '0;

endmodule

// File: tb/tb_target_lut_loader.sv
// Self-checking bench: two loader instances (default and 8-entry wrapped base) against a byte-memory model.
module tb_target_lut_loader;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic        reset;
  logic        start_a, start_b;
  logic        rd_a, rd_b;
  logic [7:0]  addr_a, addr_b;
  logic [7:0]  rdata_a, rdata_b;
  logic        busy_a, busy_b, ready_a, ready_b;
  logic [4:0]  idx_a;
  logic [2:0]  idx_b;
  logic [15:0] tgt_a, tgt_b;
`ifdef TLL_RUNTIME_WR_EN
  logic        wr_en;
  logic [4:0]  wr_idx;
  logic [15:0] wr_data;
  logic        wr_en_b;
  logic [2:0]  wr_idx_b;
  logic [15:0] wr_data_b;
`endif

  logic [7:0] mem [256];
  logic [7:0] qa[$];
  logic [7:0] qb[$];
  int n_checks = 0;
  int n_fail   = 0;
  int viol_a   = 0;
  int viol_b   = 0;

  target_lut_loader dut_a (
    .CLK(CLK), .reset(reset), .start(start_a),
    .mem_rd_en(rd_a), .mem_addr(addr_a), .mem_rdata(rdata_a),
    .busy(busy_a), .ready(ready_a), .lut_idx(idx_a), .lut_target(tgt_a)
`ifdef TLL_RUNTIME_WR_EN
    , .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data)
`endif
  );

  target_lut_loader #(.IDX_W(3), .BASE_ADDR(8'd250)) dut_b (
    .CLK(CLK), .reset(reset), .start(start_b),
    .mem_rd_en(rd_b), .mem_addr(addr_b), .mem_rdata(rdata_b),
    .busy(busy_b), .ready(ready_b), .lut_idx(idx_b), .lut_target(tgt_b)
`ifdef TLL_RUNTIME_WR_EN
    , .wr_en(wr_en_b), .wr_idx(wr_idx_b), .wr_data(wr_data_b)
`endif
  );

  // Byte memory: data one cycle after the strobe, garbage otherwise.
  always @(posedge CLK) begin
    rdata_a <= rd_a ? mem[addr_a] : 8'($urandom);
    rdata_b <= rd_b ? mem[addr_b] : 8'($urandom);
  end

  always @(negedge CLK) begin
    if (rd_a) qa.push_back(addr_a);
    else if (addr_a != 8'd0) viol_a++;
    if (rd_b) qb.push_back(addr_b);
    else if (addr_b != 8'd0) viol_b++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [15:0] exp_entry(input int base, input int k);
    return {mem[8'((base + 2*k) % 256)], mem[8'((base + 2*k + 1) % 256)]};
  endfunction

  task automatic rand_region(input int base, input int nbytes);
    for (int j = 0; j < nbytes; j++) mem[8'((base + j) % 256)] = 8'($urandom);
  endtask

  task automatic check_addrs(input string tag, input logic [7:0] q[$], input int base, input int nreads);
    chk({tag, "_nreads"}, 32'(q.size()), 32'(nreads));
    for (int j = 0; j < q.size() && j < nreads; j++)
      chk($sformatf("%s_addr%0d", tag, j), 32'(q[j]), 32'((base + j) % 256));
  endtask

  task automatic check_table_a(input string tag);
    for (int k = 0; k < 32; k++) begin
      idx_a = 5'(k);
      #1;
      chk($sformatf("%s_e%0d", tag, k), 32'(tgt_a), 32'(exp_entry(128, k)));
    end
  endtask

  // Pulse start on A and wait for ready; optional stray start / busy write at a given cycle.
  task automatic run_load_a(input string tag, input int restart_at, input int wr_at);
    int n;
    int zv;
    zv = 0;
    qa.delete();
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    n = 1;
    chk({tag, "_busy_first"}, 32'(busy_a), 32'd1);
    chk({tag, "_ready_first"}, 32'(ready_a), 32'd0);
    while (!ready_a && n < 200) begin
      idx_a = 5'($urandom);
      #1;
      if (tgt_a !== 16'd0) zv++;
      if (n == restart_at) start_a = 1'b1;
`ifdef TLL_RUNTIME_WR_EN
      if (n == wr_at) begin
        wr_en = 1'b1; wr_idx = 5'd7; wr_data = 16'h1234;
      end
`endif
      tick();
      start_a = 1'b0;
`ifdef TLL_RUNTIME_WR_EN
      wr_en = 1'b0;
`endif
      n++;
    end
    if (wr_at < 0) zv = zv + 0;
    chk({tag, "_latency"}, 32'(n), 32'd66);
    chk({tag, "_lut_zero_during_load"}, 32'(zv), 32'd0);
    chk({tag, "_busy_done"}, 32'(busy_a), 32'd0);
    check_addrs(tag, qa, 128, 64);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset = 1'b1; start_a = 1'b0; start_b = 1'b0; idx_a = '0; idx_b = '0;
`ifdef TLL_RUNTIME_WR_EN
    wr_en = 1'b0; wr_idx = '0; wr_data = '0;
    wr_en_b = 1'b0; wr_idx_b = '0; wr_data_b = '0;
`endif
    for (int j = 0; j < 256; j++) mem[j] = 8'($urandom);
    repeat (3) tick();
    reset = 1'b0;

    // Idle after reset
    repeat (10) tick();
    chk("idle_rd_en", 32'(rd_a), 32'd0);
    chk("idle_busy", 32'(busy_a), 32'd0);
    chk("idle_ready", 32'(ready_a), 32'd0);
    chk("idle_b_ready", 32'(ready_b), 32'd0);
    for (int i = 0; i < 4; i++) begin
      idx_a = 5'($urandom);
      #1;
      chk("idle_lut_zero", 32'(tgt_a), 32'd0);
    end

    // Deterministic pattern load
    for (int k = 0; k < 32; k++) begin
      mem[128 + 2*k] = 8'(k);
      mem[129 + 2*k] = 8'(8'hA0 + k);
    end
    run_load_a("load1", 0, -1);
    chk("load1_ready", 32'(ready_a), 32'd1);
    idx_a = 5'd5;  #1; chk("load1_idx5", 32'(tgt_a), 32'h05A5);
    idx_a = 5'd31; #1; chk("load1_idx31", 32'(tgt_a), 32'h1FBF);
    check_table_a("load1");
    chk("load1_addr_zero_idle", 32'(viol_a), 32'd0);

    // Reload from DONE with random data and a stray start mid-load
    rand_region(128, 64);
    run_load_a("reload", 20, -1);
    check_table_a("reload");
    repeat (4) begin
      idx_a = 5'($urandom);
      #1;
      chk("reload_rand_lookup", 32'(tgt_a), 32'(exp_entry(128, int'(idx_a))));
    end

    // Reset mid-load, then a clean load
    rand_region(128, 64);
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    repeat (29) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    idx_a = 5'd0;
    #1;
    chk("rst_busy", 32'(busy_a), 32'd0);
    chk("rst_ready", 32'(ready_a), 32'd0);
    chk("rst_rd_en", 32'(rd_a), 32'd0);
    chk("rst_lut0", 32'(tgt_a), 32'd0);
    tick();
    chk("rst_rd_en_after", 32'(rd_a), 32'd0);
    rand_region(128, 64);
    run_load_a("after_rst", 0, -1);
    check_table_a("after_rst");

    // Wrapping base on the 8-entry instance
    rand_region(250, 16);
    qb.delete();
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    n = 1;
    while (!ready_b && n < 100) begin
      tick();
      n++;
    end
    chk("wrap_latency", 32'(n), 32'd18);
    check_addrs("wrap", qb, 250, 16);
    chk("wrap_addr_zero_idle", 32'(viol_b), 32'd0);
    idx_b = 3'd3;
    #1;
    chk("wrap_e3_bytes01", 32'(tgt_b), 32'({mem[0], mem[1]}));
    for (int k = 0; k < 8; k++) begin
      idx_b = 3'(k);
      #1;
      chk($sformatf("wrap_e%0d", k), 32'(tgt_b), 32'(exp_entry(250, k)));
    end

`ifdef TLL_RUNTIME_WR_EN
    // Runtime write in DONE takes effect; the same write while busy does not
    idx_a = 5'd7;
    wr_en = 1'b1; wr_idx = 5'd7; wr_data = 16'hBEEF;
    #1;
    chk("rtwr_same_cycle_old", 32'(tgt_a), 32'(exp_entry(128, 7)));
    tick();
    wr_en = 1'b0;
    chk("rtwr_done", 32'(tgt_a), 32'hBEEF);
    idx_a = 5'd6;
    #1;
    chk("rtwr_neighbour", 32'(tgt_a), 32'(exp_entry(128, 6)));
    run_load_a("rtwr_busy", 0, 40);
    idx_a = 5'd7;
    #1;
    chk("rtwr_busy_ignored", 32'(tgt_a), 32'(exp_entry(128, 7)));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
